// File: rtl/tstdp_engine.sv
// tstdp_engine: parametrised triplet-STDP learning engine for a single synapse.
// Define TSTDP_TRIPLET_EN to include the triplet terms (r2/o2 traces and the shared multiplier).
module tstdp_engine #(
    parameter int TICK_DIV     = 6250,
    parameter int TRACE_W      = 16,
    parameter int FRAC         = 15,
    parameter int TAU_PLUS_SH  = 4,
    parameter int TAU_X_SH     = 10,
    parameter int TAU_MINUS_SH = 7,
    parameter int TAU_Y_SH     = 5,
    parameter int A2P_SH       = 12,
    parameter int A2M_SH       = 9,
    parameter int A3P_SH       = 7,
    parameter int A3M_SH       = 10,
    parameter int WEIGHT_W     = 18,
    parameter int W_MIN        = 0,
    parameter int W_MAX        = 32768,
    parameter int W_INIT       = 16384
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       pre_spike,
    input  logic                       post_spike,
    input  logic                       w_load,
    input  logic signed [WEIGHT_W-1:0] w_load_val,
    output logic signed [WEIGHT_W-1:0] weight,
    output logic                       weight_valid,
    output logic                       busy,
    output logic                       pre_event,
    output logic                       post_event,
    output logic                       sat_hit
);
    localparam int CW = $clog2(TICK_DIV);
    localparam int SW = WEIGHT_W + 2;
    localparam int DW = TRACE_W + 1;
    localparam logic [TRACE_W-1:0] ONE = TRACE_W'(1) << FRAC;
    localparam logic signed [SW-1:0] LO = SW'(W_MIN);
    localparam logic signed [SW-1:0] HI = SW'(W_MAX);

    typedef enum logic [2:0] {IDLE, CAPTURE, MUL_DEP, MUL_POT, UPDATE} state_t;

    state_t state;
    logic [2:0] pre_sy, post_sy;
    logic pre_edge, post_edge, pre_pend, post_pend, tick, pe, qe, sup, clip;
    logic [CW-1:0] cnt;
    logic [TRACE_W-1:0] r1, o1, r1_d, o1_d, trip_dep, trip_pot;
    logic [DW-1:0] dep, pot;
    logic signed [SW-1:0] sum;
    logic signed [WEIGHT_W-1:0] w_next;

    function automatic logic [TRACE_W-1:0] decay(input logic [TRACE_W-1:0] x, input int sh);
        return x - (x >> sh);
    endfunction

    assign pre_edge  = pre_sy[1] & ~pre_sy[2];
    assign post_edge = post_sy[1] & ~post_sy[2];
    assign tick      = enable && cnt == CW'(TICK_DIV - 1);
    assign busy      = state != IDLE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_sy  <= '0;
            post_sy <= '0;
        end else begin
            pre_sy  <= {pre_sy[1:0], pre_spike};
            post_sy <= {post_sy[1:0], post_spike};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (enable)
            cnt <= (cnt == CW'(TICK_DIV - 1)) ? '0 : cnt + CW'(1);
    end

    // An edge arriving during CAPTURE belongs to the following tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_pend  <= 1'b0;
            post_pend <= 1'b0;
        end else if (!enable) begin
            pre_pend  <= 1'b0;
            post_pend <= 1'b0;
        end else begin
            pre_pend  <= (state == CAPTURE) ? pre_edge : (pre_pend | pre_edge);
            post_pend <= (state == CAPTURE) ? post_edge : (post_pend | post_edge);
        end
    end

`ifdef TSTDP_TRIPLET_EN
    logic [TRACE_W-1:0] r2, o2, r2_d, o2_d;
    logic [2*TRACE_W-1:0] mul_a, mul_b, prod;
    assign mul_a    = {{TRACE_W{1'b0}}, state == MUL_DEP ? r2 : o2};
    assign mul_b    = {{TRACE_W{1'b0}}, state == MUL_DEP ? o1_d : r1_d};
    assign prod     = mul_a * mul_b;
    assign trip_dep = TRACE_W'(prod >> (FRAC + A3M_SH));
    assign trip_pot = TRACE_W'(prod >> (FRAC + A3P_SH));
`else
    assign trip_dep = '0;
    assign trip_pot = '0;
`endif

    // Sum is formed two bits wider than the weight so the clamp sees true overflow.
    always_comb begin
        sum    = SW'(weight) - $signed(SW'(dep)) + $signed(SW'(pot));
        clip   = sum < LO || sum > HI;
        w_next = sum < LO ? WEIGHT_W'(LO) : sum > HI ? WEIGHT_W'(HI) : WEIGHT_W'(sum);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            pe           <= 1'b0;
            qe           <= 1'b0;
            sup          <= 1'b0;
            r1           <= '0;
            o1           <= '0;
            r1_d         <= '0;
            o1_d         <= '0;
`ifdef TSTDP_TRIPLET_EN
            r2           <= '0;
            o2           <= '0;
            r2_d         <= '0;
            o2_d         <= '0;
`endif
            dep          <= '0;
            pot          <= '0;
            weight       <= WEIGHT_W'(W_INIT);
            weight_valid <= 1'b0;
            pre_event    <= 1'b0;
            post_event   <= 1'b0;
            sat_hit      <= 1'b0;
        end else begin
            weight_valid <= 1'b0;
            pre_event    <= 1'b0;
            post_event   <= 1'b0;
            if (w_load) begin
                weight  <= w_load_val;
                sat_hit <= 1'b0;
            end
            case (state)
                IDLE: begin
                    sup <= 1'b0;
                    if (tick)
                        state <= CAPTURE;
                end
                CAPTURE: begin
                    pe         <= pre_pend;
                    qe         <= post_pend;
                    pre_event  <= pre_pend;
                    post_event <= post_pend;
                    r1_d       <= decay(r1, TAU_PLUS_SH);
                    o1_d       <= decay(o1, TAU_MINUS_SH);
`ifdef TSTDP_TRIPLET_EN
                    r2_d       <= decay(r2, TAU_X_SH);
                    o2_d       <= decay(o2, TAU_Y_SH);
`endif
                    state      <= MUL_DEP;
                end
                MUL_DEP: begin
                    dep   <= pe ? DW'(o1_d >> A2M_SH) + DW'(trip_dep) : '0;
                    state <= MUL_POT;
                end
                MUL_POT: begin
                    pot   <= qe ? DW'(r1_d >> A2P_SH) + DW'(trip_pot) : '0;
                    state <= UPDATE;
                end
                UPDATE: begin
                    r1 <= pe ? ONE : r1_d;
                    o1 <= qe ? ONE : o1_d;
`ifdef TSTDP_TRIPLET_EN
                    r2 <= pe ? ONE : r2_d;
                    o2 <= qe ? ONE : o2_d;
`endif
                    if (!sup && !w_load) begin
                        weight       <= w_next;
                        weight_valid <= 1'b1;
                        sat_hit      <= sat_hit | clip;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // A load during an update owns the weight for that tick.
            if (w_load && state != IDLE)
                sup <= 1'b1;
        end
    end
endmodule

// File: tb/tb_tstdp_engine.sv
// tb_tstdp_engine: directed-vector bench for tstdp_engine with hand-computed weights.
module tb_tstdp_engine;
    localparam int WW = 18;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic pre_spike = 1'b0;
    logic post_spike = 1'b0;
    logic w_load = 1'b0;
    logic signed [WW-1:0] w_load_val = '0;
    logic signed [WW-1:0] weight;
    logic weight_valid, busy, pre_event, post_event, sat_hit;

    int checks = 0;
    int failures = 0;
    int npre, npost, lat, nvalid;
    bit got_valid, got_busy;

    tstdp_engine #(.TICK_DIV(24)) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .pre_spike(pre_spike),
        .post_spike(post_spike),
        .w_load(w_load),
        .w_load_val(w_load_val),
        .weight(weight),
        .weight_valid(weight_valid),
        .busy(busy),
        .pre_event(pre_event),
        .post_event(post_event),
        .sat_hit(sat_hit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b0;
        pre_spike = 1'b0;
        post_spike = 1'b0;
        w_load = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        enable = 1'b1;
    endtask

    task automatic load(input int v);
        @(negedge clk);
        w_load = 1'b1;
        w_load_val = WW'(v);
        @(negedge clk);
        w_load = 1'b0;
    endtask

    // Drives npulse single-cycle pre pulses and/or one post pulse, then waits for the update.
    task automatic step(input int npulse, input bit post, input string tag);
        int bi;
        npre = 0;
        npost = 0;
        got_valid = 0;
        bi = -1;
        lat = -1;
        for (int i = 0; i < 80 && !got_valid; i++) begin
            @(negedge clk);
            if (pre_event) npre++;
            if (post_event) npost++;
            if (busy && bi < 0) bi = i;
            if (weight_valid) begin
                got_valid = 1;
                lat = i - bi;
            end
            pre_spike = (i < 2 * npulse) && (i % 2 == 0);
            post_spike = post && i < 2;
        end
        pre_spike = 1'b0;
        post_spike = 1'b0;
        check({tag, "_valid"}, int'(got_valid), 1);
    endtask

    task automatic start_update();
        got_busy = 0;
        for (int i = 0; i < 80 && !got_busy; i++) begin
            @(negedge clk);
            if (busy) got_busy = 1;
            pre_spike = i < 2;
        end
        pre_spike = 1'b0;
        check("busy_seen", int'(got_busy), 1);
    endtask

    task automatic count_valid(input int n);
        nvalid = 0;
        repeat (n) begin
            @(negedge clk);
            if (weight_valid) nvalid++;
        end
    endtask

    initial begin
        do_reset();
        check("rst_weight", weight, 16384);
        check("rst_busy", int'(busy), 0);
        check("rst_sat", int'(sat_hit), 0);
        check("rst_valid", int'(weight_valid), 0);

        step(1, 0, "pair_pre");
        check("pair_pre_w", weight, 16384);
        check("pair_pre_ev", npre, 1);
        check("pair_pre_post_ev", npost, 0);
        step(0, 1, "pair_post");
        check("pot_w", weight, 16391);
        check("pot_post_ev", npost, 1);
        check("valid_latency", lat, 4);

        do_reset();
        step(0, 1, "dep_post");
        step(1, 0, "dep_pre");
        check("dep_w", weight, 16321);
        check("dep_pre_ev", npre, 1);

        do_reset();
        step(1, 0, "tr_a");
        step(0, 1, "tr_b");
        step(0, 1, "tr_c");
`ifdef TSTDP_TRIPLET_EN
        check("triplet_w", weight, 16623);
`else
        check("triplet_w", weight, 16398);
`endif

        do_reset();
        load(32765);
        check("load_w", weight, 32765);
        step(1, 0, "sat_a");
        check("sat_pre_flag", int'(sat_hit), 0);
        step(0, 1, "sat_b");
        check("sat_w", weight, 32768);
        check("sat_flag", int'(sat_hit), 1);
        load(100);
        check("reload_w", weight, 100);
        check("reload_sat", int'(sat_hit), 0);

        do_reset();
        step(1, 0, "both_a");
        step(1, 1, "both_b");
        check("both_w", weight, 16391);
        check("both_pre_ev", npre, 1);
        check("both_post_ev", npost, 1);
        step(1, 0, "both_c");
`ifdef TSTDP_TRIPLET_EN
        check("both_next_w", weight, 16297);
`else
        check("both_next_w", weight, 16328);
`endif
        step(3, 0, "merge");
        check("merge_pre_ev", npre, 1);

        do_reset();
        load(5000);
        check("pre_rst_w", weight, 5000);
        start_update();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_w", weight, 16384);
        check("midrst_busy", int'(busy), 0);
        reset = 1'b0;
        count_valid(10);
        check("midrst_valid", nvalid, 0);

        do_reset();
        step(0, 0, "en_sync");
        @(negedge clk);
        pre_spike = 1'b1;
        repeat (2) @(negedge clk);
        pre_spike = 1'b0;
        repeat (4) @(negedge clk);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        step(0, 0, "en_after");
        check("en_pre_ev", npre, 0);
        check("en_w", weight, 16384);

        start_update();
        w_load = 1'b1;
        w_load_val = WW'(777);
        @(negedge clk);
        w_load = 1'b0;
        count_valid(10);
        check("busyload_valid", nvalid, 0);
        check("busyload_w", weight, 777);
        check("busyload_busy", int'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tstdp_engine.md
Name: tstdp_engine

Overview:
- Parametrised triplet-STDP learning engine for one synapse.
- Generalises the fixed-constant TSTDP block: trace widths, time constants, learning-rate shifts, tick rate and weight bounds are all parameters.
- Adds spike synchronisation, a sticky event latch per tick, one shared sequential multiplier, weight saturation, weight preload and an update-valid strobe.
- Drives the UART weight reporter and the debug LEDs.

Parameters:
- TICK_DIV, 6250: clk cycles per learning tick; legal range >= 8.
- TRACE_W, 16: unsigned trace width.
- FRAC, 15: fractional bits. ONE = 1<<FRAC = 32768.
- TAU_PLUS_SH, 4: r1 decay shift.
- TAU_X_SH, 10: r2 decay shift.
- TAU_MINUS_SH, 7: o1 decay shift.
- TAU_Y_SH, 5: o2 decay shift.
- A2P_SH, 12: pair potentiation rate shift.
- A2M_SH, 9: pair depression rate shift.
- A3P_SH, 7: triplet potentiation rate shift.
- A3M_SH, 10: triplet depression rate shift.
- WEIGHT_W, 18: signed weight width; weight LSB = 2^-FRAC.
- W_MIN, 0: lower weight clamp.
- W_MAX, 32768: upper weight clamp.
- W_INIT, 16384: weight value after reset.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- enable  in  1  run learning ticks
- pre_spike  in  1  async presynaptic spike level
- post_spike  in  1  async postsynaptic spike level
- w_load  in  1  preload strobe
- w_load_val  in  WEIGHT_W  preload value, signed
- weight  out  WEIGHT_W  current weight, signed
- weight_valid  out  1  one-cycle pulse when weight is updated by a tick
- busy  out  1  update sequence in progress
- pre_event  out  1  one-cycle pulse: tick consumed a pre event
- post_event  out  1  one-cycle pulse: tick consumed a post event
- sat_hit  out  1  sticky flag, set when a clamp occurs; cleared only by w_load or reset

Behaviour:
- Reset values (asynchronous): weight=W_INIT; r1=r2=o1=o2=0; tick counter=0; FSM=IDLE; all pending flags, pulses, busy and sat_hit = 0.
- Input path: 2-flop synchroniser on each spike input, then rising-edge detect.
- Event latch: an edge sets the sticky pre_pend / post_pend flag. Several edges within one tick merge into one event.
- Edge and capture collisions: an edge in the same cycle as CAPTURE is latched for the next tick. With enable=0, edges are ignored and pending flags are cleared.
- Tick counter: counts only while enable=1 and wraps at TICK_DIV-1. The wrap cycle issues a tick.
- Mid-update disable: if enable drops during an update, the in-flight update still completes.
- FSM sequence: IDLE -tick-> CAPTURE -> MUL_DEP -> MUL_POT -> UPDATE -> IDLE. busy=1 in every state other than IDLE.
- CAPTURE: latch pe/qe from the pend flags and clear the flags.
  - Decayed values: x_d = x - (x >> TAU_SH) for r1, r2, o1, o2.
  - Keep r2_old = r2 and o2_old = o2.
  - Pulse pre_event/post_event.
- MUL_DEP:
  - dep = pe ? (o1_d>>A2M_SH) + ((r2_old*o1_d)>>(FRAC+A3M_SH)) : 0.
  - Multiplier: unsigned TRACE_W x TRACE_W -> 2*TRACE_W.
- MUL_POT: pot = qe ? (r1_d>>A2P_SH) + ((o2_old*r1_d)>>(FRAC+A3P_SH)) : 0. This reuses the same multiplier.
- UPDATE:
  - Trace update: r1 = r2 = pe ? ONE : decayed value; o1 = o2 = qe ? ONE : decayed value.
  - Weight update: weight = clamp(weight - dep + pot, W_MIN, W_MAX), computed at WEIGHT_W+2 bits before clamping.
  - weight_valid pulses high on the cycle after UPDATE, i.e. 5 clk after the tick cycle. If the clamp bound is reached, sat_hit is set.
- Simultaneous pre and post in one tick: both terms are applied. Each term uses the decayed opposite trace, not ONE.
- w_load in IDLE: weight = w_load_val and sat_hit = 0 on the next edge.
- w_load while busy: the load wins. The FSM still finishes its trace updates, but the weight write and weight_valid for that tick are suppressed.
- No tick is ever lost: TICK_DIV >= 8 guarantees IDLE before the next tick.

Optional Feature:
- Macro: TSTDP_TRIPLET_EN.
- Defined: the triplet terms are included as above.
- Undefined:
  - Pair-only STDP.
  - The multiplier is removed and the triplet terms are 0.
  - r2/o2 are not implemented.
  - MUL_DEP and MUL_POT still occupy one cycle each, so latency is unchanged.

Test Plan:
- Reset, enable=1, pre edge before tick k, post edge before tick k+1 -> weight 16384 -> 16391 (r1_d=30720, >>12 = 7). weight_valid pulses 5 clk after tick k+1.
- Reset, post before tick k, pre before tick k+1 -> o1_d=32512, dep=63, weight 16384 -> 16321, pre_event pulses once.
- Pre at tick k, post at k+1, post at k+2:
  - With TRIPLET_EN: r1_d=28800, pot=7+225, weight 16391 -> 16623.
  - Without TRIPLET_EN: weight 16391 -> 16398.
- w_load 32765, then pre at tick k, post at tick k+1 -> raw 32772 clamped to 32768, sat_hit=1. A subsequent w_load 100 -> weight=100, sat_hit=0.
- After pre at k, pre and post together at k+1 -> dep=0, pot=7, weight=16391, then r1=r2=o1=o2=32768. Three pre edges within one tick -> one pre_event.
- Assert reset during MUL_POT -> weight=16384, busy=0, no weight_valid. Toggle enable=0 with a spike pending -> no event at the next enabled tick.
